// File: rtl/inv_round_tf_if.sv
//------------------------------------------------------------------------------
// inv_round_tf_if
//   Start/done handshake and data bus of the AES inverse round datapath.
//   master : round controller side (drives start/last/state/key)
//   slave  : inv_round_tf side (returns results and status)
//   Signals:
//     start_i  1    start request
//     last_i   1    final round, skip InvMixColumns
//     s_i      128  round input state
//     rk_i     128  round key
//     s_sb_o   128  state after InvShiftRows+InvSubBytes
//     s_o      128  round output state
//     done_o   1    one-cycle result-valid pulse
//     busy_o   1    round in progress
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inv_round_tf_if;
  logic         start_i;
  logic         last_i;
  logic [127:0] s_i;
  logic [127:0] rk_i;
  logic [127:0] s_sb_o;
  logic [127:0] s_o;
  logic         done_o;
  logic         busy_o;

  modport master (
    output start_i, last_i, s_i, rk_i,
    input  s_sb_o, s_o, done_o, busy_o
  );

  modport slave (
    input  start_i, last_i, s_i, rk_i,
    output s_sb_o, s_o, done_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/inv_round_tf.sv
//------------------------------------------------------------------------------
// inv_round_tf
//   One AES decryption round: InvShiftRows, byte-serial InvSubBytes
//   (LANES lookups per cycle), AddRoundKey and, except on the final round,
//   InvMixColumns. Inputs are captured on start; done pulses one cycle when
//   s_o / s_sb_o are updated.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of inv_round_tf_if (handshake, state, key, results)
//   Parameter:
//     LANES  inverse S-box lookups per cycle (1,2,4,8,16)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module inv_round_tf #(
  parameter int LANES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  inv_round_tf_if.slave bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Element 0 is the most significant byte, so st[k] is byte k.
  typedef logic [0:15][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // out(r,c) = in(r,(c-r) mod 4)
  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[4*c+w] = s[4*((c-w) & 3) + w];
      end
    end
    return r;
  endfunction

  // Multiples 9/b/d/e built from the xtime chain x2, x4, x8.
  function automatic state_t inv_mix_columns(input state_t s);
    state_t     r;
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a     = s[4*c+i];
        x2    = xt(a);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[i] = x8 ^ a;
        mb[i] = x8 ^ x2 ^ a;
        md[i] = x8 ^ x4 ^ a;
        me[i] = x8 ^ x4 ^ x2;
      end
      r[4*c+0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[4*c+1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[4*c+2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[4*c+3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

  state_e       state, state_nxt;
  state_t       st, st_nxt, key, t;
  logic         lst;
  logic [CW-1:0] cnt;
  logic [127:0] sb_q, out_q;
  logic         done_q;

  // Each lane owns one S-box table and rewrites one byte per SUB cycle.
  logic [3:0] lane_idx [LANES];
  logic [7:0] lane_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(int'(cnt) * LANES + l);
    assign lane_out[l] = inv_sbox(st[lane_idx[l]]);
  end

  always_comb begin
    st_nxt = st;
    for (int l = 0; l < LANES; l++) begin
      st_nxt[lane_idx[l]] = lane_out[l];
    end
  end

  assign t = st ^ key;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = SUB;
      SUB:     if (cnt == CW'(N - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      st     <= '0;
      key    <= '0;
      lst    <= 1'b0;
      cnt    <= '0;
      sb_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            st  <= inv_shift_rows(bus.s_i);
            key <= bus.rk_i;
            lst <= bus.last_i;
            cnt <= '0;
          end
        end
        SUB: begin
          st  <= st_nxt;
          cnt <= cnt + 1'b1;
        end
        FIN: begin
          sb_q   <= st;
          out_q  <= lst ? t : inv_mix_columns(t);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.s_sb_o = sb_q;
  assign bus.s_o    = out_q;
  assign bus.done_o = done_q;
  assign bus.busy_o = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_inv_round_tf.sv
//------------------------------------------------------------------------------
// tb_inv_round_tf
//   Directed-vector bench for inv_round_tf. Three instances (LANES 4, 1, 16)
//   share one stimulus; results are compared against hand constants and an
//   independent software model (S-box derived from GF(2^8) inversion).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inv_round_tf;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         last_in;
  logic [127:0] s_in;
  logic [127:0] rk_in;

  int errors = 0;
  int checks = 0;

  inv_round_tf_if if4 ();
  inv_round_tf_if if1 ();
  inv_round_tf_if if16 ();

  assign if4.start_i  = start;  assign if4.last_i  = last_in;
  assign if4.s_i      = s_in;   assign if4.rk_i    = rk_in;
  assign if1.start_i  = start;  assign if1.last_i  = last_in;
  assign if1.s_i      = s_in;   assign if1.rk_i    = rk_in;
  assign if16.start_i = start;  assign if16.last_i = last_in;
  assign if16.s_i     = s_in;   assign if16.rk_i   = rk_in;

  inv_round_tf #(.LANES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  inv_round_tf #(.LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  inv_round_tf #(.LANES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- software model ----------------
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_isb();
    logic [7:0] inv, sb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      isb[sb] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_sb(input logic [127:0] s);
    logic [127:0] r;
    int rr, cc, src;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      rr  = k % 4;
      cc  = k / 4;
      src = 4 * (((cc - rr) + 4) % 4) + rr;
      r[127-8*k -: 8] = isb[s[127-8*src -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] model_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   rw [4];
    logic [7:0]   acc;
    rw[0] = 8'h0e; rw[1] = 8'h0b; rw[2] = 8'h0d; rw[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], rw[(j - i + 4) % 4]);
        r[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One round on all three instances; inputs are scrambled after acceptance.
  task automatic do_round(input logic [127:0] s, input logic [127:0] rk, input logic lst,
                          input logic [127:0] e_sb, input logic [127:0] e_o, input string tag);
    int lat4, lat1, lat16, np4, np1, np16;
    logic [127:0] o4, sb4, o1, sb1, o16, sb16;
    lat4 = -1; lat1 = -1; lat16 = -1; np4 = 0; np1 = 0; np16 = 0;
    o4 = '0; sb4 = '0; o1 = '0; sb1 = '0; o16 = '0; sb16 = '0;
    @(negedge clk);
    start = 1'b1; s_in = s; rk_in = rk; last_in = lst;
    @(posedge clk); #1;
    start = 1'b0; s_in = ~s; rk_in = ~rk; last_in = ~lst;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if4.done_o) begin
        np4++;
        if (lat4 < 0) begin lat4 = k; o4 = if4.s_o; sb4 = if4.s_sb_o; end
      end
      if (if1.done_o) begin
        np1++;
        if (lat1 < 0) begin lat1 = k; o1 = if1.s_o; sb1 = if1.s_sb_o; end
      end
      if (if16.done_o) begin
        np16++;
        if (lat16 < 0) begin lat16 = k; o16 = if16.s_o; sb16 = if16.s_sb_o; end
      end
      if (lat1 >= 0 && k > lat1) break;
    end
    chk({tag, "/lat4"},  lat4,  5);
    chk({tag, "/lat1"},  lat1,  17);
    chk({tag, "/lat16"}, lat16, 2);
    chk({tag, "/pulses"}, {np4[7:0], np1[7:0], np16[7:0]}, {8'd1, 8'd1, 8'd1});
    chk({tag, "/sb4"},  sb4,  e_sb);
    chk({tag, "/o4"},   o4,   e_o);
    chk({tag, "/sb1"},  sb1,  e_sb);
    chk({tag, "/o1"},   o1,   e_o);
    chk({tag, "/sb16"}, sb16, e_sb);
    chk({tag, "/o16"},  o16,  e_o);
  endtask

  typedef struct {
    logic [127:0] s;
    logic [127:0] rk;
    logic         last;
    logic [127:0] sb;
    logic [127:0] o;
  } vec_t;

  vec_t tv [5];

  initial begin
    logic [127:0] rs, rk, esb;
    logic         rl;
    int           nd;
    bit           ed, eb;

    rst_n = 1'b0; start = 1'b0; last_in = 1'b0; s_in = '0; rk_in = '0;
    build_isb();

    // T1 final round, T2 final/normal, T3 InvMixColumns column, mixed key
    tv[0] = '{s: 128'h6353e08c0960e104cd70b751bacad0e7, rk: 128'h000102030405060708090a0b0c0d0e0f,
              last: 1'b1, sb: 128'h00102030405060708090a0b0c0d0e0f0, o: 128'h00112233445566778899aabbccddeeff};
    tv[1] = '{s: 128'h7ad5fda789ef4e272bca100b3d9ff59f, rk: '0,
              last: 1'b1, sb: 128'hbd6e7c3df2b5779e0b61216e8b10b689, o: 128'hbd6e7c3df2b5779e0b61216e8b10b689};
    tv[2] = '{s: 128'h7ad5fda789ef4e272bca100b3d9ff59f, rk: '0,
              last: 1'b0, sb: 128'hbd6e7c3df2b5779e0b61216e8b10b689,
              o: model_mix(128'hbd6e7c3df2b5779e0b61216e8b10b689)};
    tv[3] = '{s: 128'h19000000000000650000320000e30000, rk: '0, last: 1'b0,
              sb: model_sb(128'h19000000000000650000320000e30000),
              o: model_mix(model_sb(128'h19000000000000650000320000e30000))};
    tv[4] = '{s: 128'h6353e08c0960e104cd70b751bacad0e7, rk: 128'h2b7e151628aed2a6abf7158809cf4f3c,
              last: 1'b0, sb: 128'h00102030405060708090a0b0c0d0e0f0,
              o: model_mix(128'h00102030405060708090a0b0c0d0e0f0 ^ 128'h2b7e151628aed2a6abf7158809cf4f3c)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst/s_o",    if4.s_o,    '0);
    chk("rst/s_sb_o", if4.s_sb_o, '0);
    chk("rst/done",   if4.done_o, 0);
    chk("rst/busy",   if4.busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_round(tv[i].s, tv[i].rk, tv[i].last, tv[i].sb, tv[i].o, $sformatf("tv%0d", i));
      if (i == 3) begin
        chk("t3/sb_col0",  if4.s_sb_o[127:96], 32'h8e4da1bc);
        chk("t3/out_col0", if4.s_o[127:96],    32'hdb135345);
      end
    end

    // Outputs hold while idle
    repeat (5) @(posedge clk);
    #1;
    chk("hold/s_o", if4.s_o, tv[4].o);

    // T4: start held for 10 edges; the second start is taken in the done cycle
    @(negedge clk);
    s_in = tv[0].s; rk_in = tv[0].rk; last_in = tv[0].last; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 9) start = 1'b0;
      ed = (k == 5 || k == 11);
      eb = !(k == 5 || k >= 11);
      chk($sformatf("t4/done_c%0d", k), if4.done_o, ed);
      chk($sformatf("t4/busy_c%0d", k), if4.busy_o, eb);
    end
    chk("t4/s_o", if4.s_o, tv[0].o);
    repeat (40) @(posedge clk);

    // T5: reset during the second SUB cycle
    @(negedge clk);
    s_in = tv[2].s; rk_in = tv[2].rk; last_in = tv[2].last; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5/s_o",    if4.s_o,    '0);
    chk("t5/s_sb_o", if4.s_sb_o, '0);
    chk("t5/done",   if4.done_o, 0);
    chk("t5/busy",   if4.busy_o, 0);
    chk("t5/s_o_l1", if1.s_o,    '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (if4.done_o || if1.done_o || if16.done_o || if4.busy_o) nd++;
    end
    chk("t5/no_done", nd, 0);

    // T6 random rounds
    for (int n = 0; n < 1000; n++) begin
      rs  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rk  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rl  = 1'($urandom_range(0, 1));
      esb = model_sb(rs);
      do_round(rs, rk, rl, esb, rl ? (esb ^ rk) : model_mix(esb ^ rk), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
